// File: rtl/mx_pkg.sv
// Shared definitions for the MX block quantiser: FSM states, E8M0 constants,
// the shared-exponent offset (emax) derivation and a leading-one helper.
package mx_pkg;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_EMIT = 1'b1
  } mx_state_t;

  localparam logic [7:0] E8M0_BIAS = 8'd127;
  localparam logic [7:0] E8M0_NAN  = 8'hFF;

  // Width of the signed shared exponent carried between top and encoder.
  localparam int XW = 10;

  // Unbiased exponent of the largest finite element value.
  function automatic int mx_emax(input int e4m3_spec, input int exp_width);
    if (e4m3_spec != 0) return 8;
    return ((1 << exp_width) - 2) - ((1 << (exp_width - 1)) - 1);
  endfunction

  // floor(log2(v)) for v != 0; returns 0 for v == 0.
  function automatic int mx_log2(input logic [63:0] v);
    int p;
    p = 0;
    for (int i = 0; i < 64; i++) begin
      if (v[i]) p = i;
    end
    return p;
  endfunction

endpackage

// File: rtl/mx_fp8_enc.sv
// Combinational FP8 element encoder: value * 2^-shift -> S.E.M code.
// Rounding: round-to-nearest-even when MX_QUANT_RNE_EN is defined,
// otherwise truncation toward zero. Results saturate to max normal.
module mx_fp8_enc
  import mx_pkg::*;
#(
  parameter int in_width  = 32,
  parameter int exp_width = 4,
  parameter int man_width = 3,
  parameter int e4m3_spec = 1
) (
  input  logic [in_width:0]            value,
  input  logic signed [XW-1:0]         shift,
  input  logic                         sign,
  output logic [exp_width+man_width:0] elem
);

  localparam int MW   = in_width + 1;
  localparam int CW   = exp_width + man_width;
  localparam int QW   = MW + 24;
  localparam int BIAS = (1 << (exp_width - 1)) - 1;
  // Largest finite magnitude code (E4M3 reuses the all-ones exponent).
  localparam int MAXC = (e4m3_spec != 0) ? (1 << CW) - 2
                                         : (((1 << exp_width) - 1) << man_width) - 1;

  function automatic logic round_up(input logic lsb, input logic guard, input logic sticky);
`ifdef MX_QUANT_RNE_EN
    return guard & (sticky | lsb);
`else
    return 1'b0 & (lsb | guard | sticky);
`endif
  endfunction

  function automatic logic [CW-1:0] saturate(input int code);
    return (code > MAXC) ? CW'(MAXC) : CW'(code);
  endfunction

  // The significand q is taken in units of the target ulp, so normals and
  // subnormals share one formula: code = (max(E,1)-1) << man_width + q.
  // A rounding carry out of the mantissa lands naturally in the exponent.
  function automatic logic [CW:0] encode(input logic [MW-1:0] v,
                                         input logic signed [XW-1:0] x,
                                         input logic s);
    int eb, eeff, sh, code;
    logic [QW-1:0] wide, q, rem, half;
    logic up;
    if (v == '0) return '0;
    wide = QW'(v);
    eb   = mx_log2(64'(v)) - int'(x) + BIAS;
    eeff = (eb < 1) ? 1 : eb;
    sh   = eeff - BIAS - man_width + int'(x);
    up   = 1'b0;
    if (sh > 0) begin
      q    = wide >> sh;
      rem  = wide - (q << sh);
      half = QW'(1) << (sh - 1);
      up   = round_up(q[0], rem >= half, rem > half);
    end else begin
      q = wide << (-sh);
    end
    code = ((eeff - 1) << man_width) + int'(q[30:0]) + int'(up);
    // Anything rounding to zero becomes +0 regardless of sign.
    if (code == 0) return '0;
    return {s, saturate(code)};
  endfunction

  assign elem = encode(value, shift, sign);

endmodule

// File: rtl/mx_quant_fp8.sv
// MX block quantiser: buffers k signed integer elements, derives a shared
// E8M0 scale from the block maximum, then emits k FP8 elements.
// Optional build macro: MX_QUANT_RNE_EN selects round-to-nearest-even
// scaling (default build truncates toward zero).
module mx_quant_fp8
  import mx_pkg::*;
#(
  parameter int k         = 32,
  parameter int in_width  = 32,
  parameter int exp_width = 4,
  parameter int man_width = 3,
  parameter int e4m3_spec = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_valid,
  output logic                         o_ready,
  input  logic signed [in_width-1:0]   i_data,
  input  logic                         i_nan,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic [exp_width+man_width:0] o_elem,
  output logic [7:0]                   o_scale,
  output logic                         o_last
);

  localparam int MW   = in_width + 1;
  localparam int CW   = exp_width + man_width;
  localparam int CNTW = (k > 1) ? $clog2(k) : 1;
  localparam int EMAX = mx_emax(e4m3_spec, exp_width);
  localparam logic [CNTW-1:0] LAST = CNTW'(k - 1);

  // One extra bit so |most-negative| is representable.
  function automatic logic [MW-1:0] abs_mag(input logic signed [in_width-1:0] d);
    logic signed [MW-1:0] ext;
    ext = MW'(d);
    return (ext < 0) ? MW'(-ext) : MW'(ext);
  endfunction

  function automatic logic signed [XW-1:0] shared_exp(input logic [MW-1:0] m);
    if (m == '0) return '0;
    return XW'(mx_log2(64'(m)) - EMAX);
  endfunction

  mx_state_t                  state, state_nxt;
  logic [CNTW-1:0]            cnt;
  logic [MW-1:0]              max_mag, in_mag, emit_mag;
  logic                       nan_seen, accept, emit_hs, emit_sgn;
  logic signed [in_width-1:0] mem [k];
  logic signed [in_width-1:0] emit_data;
  logic signed [XW-1:0]       x_shift;
  logic [CW:0]                enc_elem;
  logic [7:0]                 scale;

  assign accept    = o_ready & i_valid;
  assign emit_hs   = o_valid & i_ready;
  assign in_mag    = abs_mag(i_data);
  assign emit_data = mem[cnt];
  assign emit_mag  = abs_mag(emit_data);
  assign emit_sgn  = emit_data[in_width-1];
  assign x_shift   = shared_exp(max_mag);
  assign scale     = nan_seen ? E8M0_NAN : 8'(int'(x_shift) + int'(E8M0_BIAS));

  mx_fp8_enc #(
    .in_width (in_width),
    .exp_width(exp_width),
    .man_width(man_width),
    .e4m3_spec(e4m3_spec)
  ) u_enc (
    .value(emit_mag),
    .shift(x_shift),
    .sign (emit_sgn),
    .elem (enc_elem)
  );

  // Outputs are pure functions of held state, so they stay put under stall.
  assign o_elem  = (state == ST_EMIT) ? (nan_seen ? {1'b0, {CW{1'b1}}} : enc_elem) : '0;
  assign o_scale = (state == ST_EMIT) ? scale : 8'h00;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_FILL;
    else     state <= state_nxt;
  end

  // FSM next state and handshake outputs.
  always_comb begin
    state_nxt = state;
    o_ready   = 1'b0;
    o_valid   = 1'b0;
    o_last    = 1'b0;
    unique case (state)
      ST_FILL: begin
        o_ready = 1'b1;
        if (i_valid && (cnt == LAST)) state_nxt = ST_EMIT;
      end
      ST_EMIT: begin
        o_valid = 1'b1;
        o_last  = (cnt == LAST);
        if (i_ready && (cnt == LAST)) state_nxt = ST_FILL;
      end
      default: state_nxt = ST_FILL;
    endcase
  end

  // Element index and block max / NaN trackers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      max_mag  <= '0;
      nan_seen <= 1'b0;
    end else if (accept) begin
      cnt      <= (cnt == LAST) ? '0 : cnt + CNTW'(1);
      nan_seen <= nan_seen | i_nan;
      if (in_mag > max_mag) max_mag <= in_mag;
    end else if (emit_hs) begin
      if (cnt == LAST) begin
        cnt      <= '0;
        max_mag  <= '0;
        nan_seen <= 1'b0;
      end else begin
        cnt <= cnt + CNTW'(1);
      end
    end
  end

  // Block buffer; data path is not reset.
  always_ff @(posedge clk) begin
    if (accept) mem[cnt] <= i_data;
  end

endmodule

// File: tb/tb_mx_quant_fp8.sv
// Directed bench for mx_quant_fp8 (k=32, E4M3, 32-bit integer input).
module tb_mx_quant_fp8;

`ifdef MX_QUANT_RNE_EN
  localparam bit RNE = 1'b1;
`else
  localparam bit RNE = 1'b0;
`endif

  logic               clk, rst, i_valid, i_nan, i_ready;
  logic signed [31:0] i_data;
  logic               o_ready, o_valid, o_last;
  logic [7:0]         o_elem, o_scale;

  logic signed [31:0] blk_data [32];
  logic               blk_nan  [32];
  logic [7:0]         exp_elem [32];
  logic [7:0]         got_elem [32];
  logic [7:0]         got_scale[32];
  logic               got_last [32];
  logic               tmo, fill_vld;
  int                 total, bad;

  mx_quant_fp8 dut (
    .clk    (clk),
    .rst    (rst),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .i_data (i_data),
    .i_nan  (i_nan),
    .o_valid(o_valid),
    .i_ready(i_ready),
    .o_elem (o_elem),
    .o_scale(o_scale),
    .o_last (o_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic clear_block();
    for (int i = 0; i < 32; i++) begin
      blk_data[i] = 32'sd0;
      blk_nan[i]  = 1'b0;
      exp_elem[i] = 8'h00;
    end
  endtask

  // Push blk_data into the DUT; note any o_valid seen while filling.
  task automatic send_block();
    int w;
    fill_vld = 1'b0;
    for (int i = 0; i < 32; i++) begin
      i_valid = 1'b1;
      i_data  = blk_data[i];
      i_nan   = blk_nan[i];
      w = 0;
      while (o_ready !== 1'b1 && w < 100) begin
        @(posedge clk); #1; w++;
      end
      if (o_ready !== 1'b1) tmo = 1'b1;
      if (o_valid !== 1'b0) fill_vld = 1'b1;
      @(posedge clk); #1;
    end
    i_valid = 1'b0;
    i_nan   = 1'b0;
    i_data  = 32'sd0;
  endtask

  // Collect one block of outputs with i_ready held high.
  task automatic drain_block();
    int w;
    i_ready = 1'b1;
    for (int i = 0; i < 32; i++) begin
      w = 0;
      while (o_valid !== 1'b1 && w < 100) begin
        @(posedge clk); #1; w++;
      end
      if (o_valid !== 1'b1) tmo = 1'b1;
      got_elem[i]  = o_elem;
      got_scale[i] = o_scale;
      got_last[i]  = o_last;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; i_valid = 1'b0; i_nan = 1'b0; i_ready = 1'b0; i_data = 32'sd0;
    tmo = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL reset o_valid got=%b exp=0", o_valid); end
    total++; if (o_last !== 1'b0) begin bad++; $display("FAIL reset o_last got=%b exp=0", o_last); end
    total++; if (o_elem !== 8'h00) begin bad++; $display("FAIL reset o_elem got=%h exp=00", o_elem); end
    total++; if (o_scale !== 8'h00) begin bad++; $display("FAIL reset o_scale got=%h exp=00", o_scale); end
    rst = 1'b0;
    @(posedge clk); #1;
    total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL reset o_ready got=%b exp=1", o_ready); end
  endtask

  // Send, check first-output latency, drain, compare every element.
  task automatic test_all_max();
    clear_block();
    for (int i = 0; i < 32; i++) begin blk_data[i] = 32'sd448; exp_elem[i] = 8'h7E; end
    send_block();
    total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL all_max latency o_valid got=%b exp=1", o_valid); end
    drain_block();
    for (int i = 0; i < 32; i++) begin
      total++;
      if ({got_elem[i], got_scale[i], got_last[i]} !== {exp_elem[i], 8'h7F, i == 31}) begin
        bad++; $display("FAIL all_max[%0d] elem/scale/last got=%h/%h/%b exp=%h/7f/%b", i, got_elem[i], got_scale[i], got_last[i], exp_elem[i], i == 31);
      end
    end
    total++; if (tmo || fill_vld || o_valid !== 1'b0 || o_ready !== 1'b1) begin bad++; $display("FAIL all_max ctrl got tmo=%b fv=%b v=%b r=%b exp 0/0/0/1", tmo, fill_vld, o_valid, o_ready); end
  endtask

  task automatic test_single_one();
    clear_block();
    blk_data[0] = 32'sd1; exp_elem[0] = 8'h78;
    send_block();
    drain_block();
    for (int i = 0; i < 32; i++) begin
      total++;
      if ({got_elem[i], got_scale[i], got_last[i]} !== {exp_elem[i], 8'h77, i == 31}) begin
        bad++; $display("FAIL single_one[%0d] elem/scale/last got=%h/%h/%b exp=%h/77/%b", i, got_elem[i], got_scale[i], got_last[i], exp_elem[i], i == 31);
      end
    end
    total++; if (tmo || fill_vld || o_valid !== 1'b0) begin bad++; $display("FAIL single_one ctrl got tmo=%b fv=%b v=%b exp 0/0/0", tmo, fill_vld, o_valid); end
  endtask

  task automatic test_rounding();
    clear_block();
    blk_data[0] = 32'sd448; exp_elem[0] = 8'h7E;
    blk_data[1] = 32'sd19;  exp_elem[1] = RNE ? 8'h5A : 8'h59;
    blk_data[2] = 32'sd472; exp_elem[2] = 8'h7E;
    blk_data[3] = 32'sd5;   exp_elem[3] = 8'h4A;
    send_block();
    drain_block();
    for (int i = 0; i < 32; i++) begin
      total++;
      if ({got_elem[i], got_scale[i]} !== {exp_elem[i], 8'h7F}) begin
        bad++; $display("FAIL rounding[%0d] elem/scale got=%h/%h exp=%h/7f", i, got_elem[i], got_scale[i], exp_elem[i]);
      end
    end
  endtask

  task automatic test_neg_nan();
    clear_block();
    blk_data[0] = 32'sd448;  exp_elem[0] = 8'h7E;
    blk_data[2] = -32'sd448; exp_elem[2] = 8'hFE;
    blk_data[3] = -32'sd19;  exp_elem[3] = RNE ? 8'hDA : 8'hD9;
    send_block();
    drain_block();
    for (int i = 0; i < 32; i++) begin
      total++;
      if ({got_elem[i], got_scale[i]} !== {exp_elem[i], 8'h7F}) begin
        bad++; $display("FAIL negative[%0d] elem/scale got=%h/%h exp=%h/7f", i, got_elem[i], got_scale[i], exp_elem[i]);
      end
    end
    clear_block();
    for (int i = 0; i < 32; i++) begin blk_data[i] = 32'sd3; exp_elem[i] = 8'h7F; end
    blk_data[0] = 32'sd448;
    blk_nan[5]  = 1'b1;
    send_block();
    drain_block();
    for (int i = 0; i < 32; i++) begin
      total++;
      if ({got_elem[i], got_scale[i], got_last[i]} !== {exp_elem[i], 8'hFF, i == 31}) begin
        bad++; $display("FAIL nan[%0d] elem/scale/last got=%h/%h/%b exp=%h/ff/%b", i, got_elem[i], got_scale[i], got_last[i], exp_elem[i], i == 31);
      end
    end
  endtask

  // Max 2^20 gives X=12: small elements land in subnormal range or flush.
  task automatic test_subnormal();
    clear_block();
    blk_data[0] = 32'sd1048576; exp_elem[0] = 8'h78;
    blk_data[1] = -32'sd1;      exp_elem[1] = 8'h00;
    blk_data[2] = 32'sd40;      exp_elem[2] = 8'h05;
    blk_data[3] = -32'sd44;     exp_elem[3] = RNE ? 8'h86 : 8'h85;
    blk_data[4] = -32'sd5000;   exp_elem[4] = RNE ? 8'hBA : 8'hB9;
    send_block();
    drain_block();
    for (int i = 0; i < 32; i++) begin
      total++;
      if ({got_elem[i], got_scale[i]} !== {exp_elem[i], 8'h8B}) begin
        bad++; $display("FAIL subnormal[%0d] elem/scale got=%h/%h exp=%h/8b", i, got_elem[i], got_scale[i], exp_elem[i]);
      end
    end
  endtask

  task automatic test_most_negative();
    clear_block();
    blk_data[0] = 32'sh80000000; exp_elem[0] = 8'hF8;
    blk_data[1] = 32'sh7FFFFFFF; exp_elem[1] = RNE ? 8'h78 : 8'h77;
    send_block();
    drain_block();
    for (int i = 0; i < 32; i++) begin
      total++;
      if ({got_elem[i], got_scale[i]} !== {exp_elem[i], 8'h96}) begin
        bad++; $display("FAIL most_negative[%0d] elem/scale got=%h/%h exp=%h/96", i, got_elem[i], got_scale[i], exp_elem[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic signed [31:0] pat_d [8];
    logic [7:0]         pat_e [8];
    pat_d = '{32'sd448, 32'sd1, 32'sd2, 32'sd3, 32'sd4, 32'sd5, 32'sd6, 32'sd7};
    pat_e = '{8'h7E, 8'h38, 8'h40, 8'h44, 8'h48, 8'h4A, 8'h4C, 8'h4E};
    clear_block();
    for (int i = 0; i < 32; i++) begin blk_data[i] = pat_d[i % 8]; exp_elem[i] = pat_e[i % 8]; end
    send_block();
    i_ready = 1'b1;
    for (int i = 0; i < 32; i++) begin
      if (i == 12) begin
        i_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          @(posedge clk); #1;
          total++;
          if ({o_valid, o_elem, o_scale, o_last} !== {1'b1, exp_elem[12], 8'h7F, 1'b0}) begin
            bad++; $display("FAIL stall[%0d] v/elem/scale/last got=%b/%h/%h/%b exp=1/%h/7f/0", s, o_valid, o_elem, o_scale, o_last, exp_elem[12]);
          end
        end
        i_ready = 1'b1;
      end
      total++;
      if ({o_valid, o_elem, o_last} !== {1'b1, exp_elem[i], i == 31}) begin
        bad++; $display("FAIL backpressure[%0d] v/elem/last got=%b/%h/%b exp=1/%h/%b", i, o_valid, o_elem, o_last, exp_elem[i], i == 31);
      end
      @(posedge clk); #1;
    end
    total++; if (o_valid !== 1'b0 || o_ready !== 1'b1) begin bad++; $display("FAIL backpressure end v/r got=%b/%b exp=0/1", o_valid, o_ready); end
  endtask

  task automatic test_reset_mid_emit();
    clear_block();
    for (int i = 0; i < 32; i++) blk_data[i] = 32'sd1048576 + i;
    send_block();
    i_ready = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++; if (o_valid !== 1'b0 || o_ready !== 1'b1) begin bad++; $display("FAIL mid_reset v/r got=%b/%b exp=0/1", o_valid, o_ready); end
    @(posedge clk); #1;
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL mid_reset idle v got=%b exp=0", o_valid); end
    clear_block();
    for (int i = 0; i < 32; i++) begin blk_data[i] = 32'sd448; exp_elem[i] = 8'h7E; end
    send_block();
    drain_block();
    for (int i = 0; i < 32; i++) begin
      total++;
      if ({got_elem[i], got_scale[i], got_last[i]} !== {exp_elem[i], 8'h7F, i == 31}) begin
        bad++; $display("FAIL after_reset[%0d] elem/scale/last got=%h/%h/%b exp=%h/7f/%b", i, got_elem[i], got_scale[i], got_last[i], exp_elem[i], i == 31);
      end
    end
    total++; if (tmo || fill_vld) begin bad++; $display("FAIL after_reset ctrl got tmo=%b fv=%b exp 0/0", tmo, fill_vld); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_all_max();
    test_single_one();
    test_rounding();
    test_neg_nan();
    test_subnormal();
    test_most_negative();
    test_backpressure();
    test_reset_mid_emit();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
